// File: rtl/tl_frag_pkg.sv
// Shared constants and width helpers for the TileLink-UL fragmenter.
package tl_frag_pkg;

  localparam logic [2:0] GET        = 3'd4;
  localparam logic [2:0] PUTFULL    = 3'd0;
  localparam logic [2:0] PUTPARTIAL = 3'd1;
  localparam logic [2:0] ACK        = 3'd0;
  localparam logic [2:0] ACKDATA    = 3'd1;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } frag_state_e;

  function automatic int unsigned beat_log2(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned frag_w(input int unsigned data_w, input int unsigned in_size_w);
    return (32'd1 << in_size_w) - 32'd1 - beat_log2(data_w);
  endfunction

  function automatic int unsigned out_size_w(input int unsigned data_w);
    return $clog2(beat_log2(data_w) + 1);
  endfunction

endpackage

// File: rtl/tl_frag_size_table.sv
// Per-source record of the original transfer size, used to restore in_d_size.
module tl_frag_size_table
  import tl_frag_pkg::*;
#(
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned ENTRY_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem_q [2**IDX_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**IDX_W; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Read sees the pre-write value when a write to the same entry is in flight.
  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/tl_fragmenter_param.sv
// TileLink-UL fragmenter: splits wide Get/Put transfers into single-beat requests
// and restores size/source on the D channel, dropping intermediate AccessAcks.
module tl_fragmenter_param
  import tl_frag_pkg::*;
#(
  parameter int unsigned ADDR_W     = 26,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IN_SRC_W   = 5,
  parameter int unsigned IN_SIZE_W  = 3,
  localparam int unsigned BEAT_LOG2  = beat_log2(DATA_W),
  localparam int unsigned FRAG_W     = frag_w(DATA_W, IN_SIZE_W),
  localparam int unsigned OUT_SRC_W  = IN_SRC_W + FRAG_W,
  localparam int unsigned OUT_SIZE_W = out_size_w(DATA_W)
) (
  input  logic                  clock,
  input  logic                  reset,

  output logic                  in_a_ready,
  input  logic                  in_a_valid,
  input  logic [2:0]            in_a_opcode,
  input  logic [2:0]            in_a_param,
  input  logic [IN_SIZE_W-1:0]  in_a_size,
  input  logic [IN_SRC_W-1:0]   in_a_source,
  input  logic [ADDR_W-1:0]     in_a_address,
  input  logic [DATA_W/8-1:0]   in_a_mask,
  input  logic [DATA_W-1:0]     in_a_data,
  input  logic                  in_a_corrupt,

  input  logic                  in_d_ready,
  output logic                  in_d_valid,
  output logic [2:0]            in_d_opcode,
  output logic [IN_SIZE_W-1:0]  in_d_size,
  output logic [IN_SRC_W-1:0]   in_d_source,
  output logic [DATA_W-1:0]     in_d_data,

  input  logic                  out_a_ready,
  output logic                  out_a_valid,
  output logic [2:0]            out_a_opcode,
  output logic [2:0]            out_a_param,
  output logic [OUT_SIZE_W-1:0] out_a_size,
  output logic [OUT_SRC_W-1:0]  out_a_source,
  output logic [ADDR_W-1:0]     out_a_address,
  output logic [DATA_W/8-1:0]   out_a_mask,
  output logic [DATA_W-1:0]     out_a_data,
  output logic                  out_a_corrupt,

  output logic                  out_d_ready,
  input  logic                  out_d_valid,
  input  logic [2:0]            out_d_opcode,
  input  logic [OUT_SIZE_W-1:0] out_d_size,
  input  logic [OUT_SRC_W-1:0]  out_d_source,
  input  logic [DATA_W-1:0]     out_d_data
);

  frag_state_e         state_q;
  logic [FRAG_W-1:0]   rem_q;

  logic                is_get;
  logic                multi;
  logic [FRAG_W-1:0]   first_rem;
  logic [FRAG_W-1:0]   cur_rem;
  logic [FRAG_W-1:0]   idx;
  logic                a_fire;
  logic                tbl_we;

  logic [FRAG_W-1:0]   d_rem;
  logic [IN_SRC_W-1:0] d_src;
  logic                d_drop;
  logic                unused_d_size;

  // ---------------- A channel ----------------
  always_comb begin
    first_rem = '0;
    if (32'(in_a_size) > BEAT_LOG2) begin
      first_rem = FRAG_W'((32'd1 << (32'(in_a_size) - BEAT_LOG2)) - 32'd1);
    end
  end

  assign is_get  = (in_a_opcode == GET);
  assign multi   = (first_rem != '0);
  assign cur_rem = (state_q == StBusy) ? rem_q : first_rem;
  assign idx     = first_rem - cur_rem;

  assign out_a_valid   = in_a_valid & reset;
  assign out_a_opcode  = in_a_opcode;
  assign out_a_param   = in_a_param;
  assign out_a_size    = multi ? OUT_SIZE_W'(BEAT_LOG2) : OUT_SIZE_W'(in_a_size);
  assign out_a_source  = {in_a_source, cur_rem};
  assign out_a_address = in_a_address + (ADDR_W'(idx) << BEAT_LOG2);
  // A multi-beat Get reads whole beats; Puts carry their own per-beat mask.
  assign out_a_mask    = (is_get && multi) ? '1 : in_a_mask;
  assign out_a_data    = in_a_data;
  assign out_a_corrupt = in_a_corrupt;

  // A Get is a single in beat held until its last fragment leaves.
  assign in_a_ready = reset & out_a_ready & (!is_get | (cur_rem == '0));
  assign a_fire     = out_a_valid & out_a_ready;
  assign tbl_we     = a_fire & (state_q == StIdle);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
    end else if (a_fire) begin
      if (cur_rem == '0) begin
        state_q <= StIdle;
        rem_q   <= '0;
      end else begin
        state_q <= StBusy;
        rem_q   <= cur_rem - FRAG_W'(1);
      end
    end
  end

  tl_frag_size_table #(
    .IDX_W   (IN_SRC_W),
    .ENTRY_W (IN_SIZE_W)
  ) u_size_table (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (tbl_we),
    .wr_idx  (in_a_source),
    .wr_data (in_a_size),
    .rd_idx  (d_src),
    .rd_data (in_d_size)
  );

  // ---------------- D channel ----------------
  assign d_rem  = out_d_source[FRAG_W-1:0];
  assign d_src  = out_d_source[OUT_SRC_W-1:FRAG_W];
  // Only the final AccessAck of a fragmented Put reaches the master.
  assign d_drop = (out_d_opcode != ACKDATA) && (d_rem != '0);

  assign in_d_valid  = reset & out_d_valid & !d_drop;
  assign out_d_ready = d_drop | in_d_ready;
  assign in_d_opcode = out_d_opcode;
  assign in_d_source = d_src;
  assign in_d_data   = out_d_data;

  assign unused_d_size = ^out_d_size;

endmodule
